// File: rtl/controle_pontuacao_if.sv
// Score-request bus between the game logic and the score-update sequencer.
// The game side (master) raises point requests and iniciar; the sequencer
// (slave) returns the counter pulses, the pending counts and the status flags.
interface controle_pontuacao_if #(
    parameter int PW = 4,
    parameter int BW = 4
) ();
    logic          iniciar;
    logic          acerto;
    logic          erro;
    logic          bonus;
    logic [BW-1:0] bonus_valor;
    logic          inc;
    logic          dec;
    logic          zera_s;
    logic [PW-1:0] pend_sobe;
    logic [PW-1:0] pend_desce;
    logic          ocupado;
    logic          perda;

    modport master (
        output iniciar, acerto, erro, bonus, bonus_valor,
        input  inc, dec, zera_s, pend_sobe, pend_desce, ocupado, perda
    );

    modport slave (
        input  iniciar, acerto, erro, bonus, bonus_valor,
        output inc, dec, zera_s, pend_sobe, pend_desce, ocupado, perda
    );
endinterface

// File: rtl/controle_pontuacao.sv
// Score-update sequencer: queues credits/debits from game events and replays
// them to the saturating score counter as single-cycle inc/dec pulses,
// alternating between directions under contention, with an optional idle gap
// after each pulse. Also drives the counter's synchronous clear on game start.
module controle_pontuacao #(
    parameter int PMAX      = 15,
    parameter int PW        = 4,
    parameter int BW        = 4,
    parameter int INTERVALO = 0
) (
    input  logic                  clock,
    input  logic                  zera_as_n,
    controle_pontuacao_if.slave   bus
);

    // Sum width wide enough for pend + max bonus + acerto without overflow.
    localparam int             SW      = PW + BW + 1;
    localparam int             GW      = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
    localparam logic [GW-1:0]  GAP_INI = GW'((INTERVALO > 0) ? INTERVALO - 1 : 0);
    localparam logic [SW-1:0]  LIM     = SW'(PMAX);

    typedef enum logic [1:0] {
        LIVRE  = 2'd0,
        ESPERA = 2'd1,
        ZERA   = 2'd2
    } estado_t;

    // Clamp a pending-count candidate to PMAX; MSB of the result flags truncation.
    function automatic logic [PW:0] satura(input logic [SW-1:0] v);
        if (v > LIM) begin
            return {1'b1, LIM[PW-1:0]};
        end
        return {1'b0, v[PW-1:0]};
    endfunction

    estado_t       r_estado, w_estado_prox;
    logic [GW-1:0] r_gap, w_gap_prox;
    logic          r_ultimo_sobe, w_ultimo_prox;   // 1: last pulse was inc

    logic [PW-1:0] r_pend_sobe, r_pend_desce;
    logic [PW-1:0] w_pend_sobe_prox, w_pend_desce_prox;
    logic          r_inc, r_dec, r_zera_s, r_ocupado, r_perda;
    logic          w_inc_prox, w_dec_prox, w_zera_prox, w_ocupado_prox, w_perda_prox;

    logic          w_emite_sobe, w_emite_desce;
    logic [SW-1:0] w_soma_sobe, w_soma_desce;
    logic [PW:0]   w_sat_sobe, w_sat_desce;

    // Issue choice from the pending counts held before this edge's additions.
    always_comb begin
        w_emite_sobe  = 1'b0;
        w_emite_desce = 1'b0;
        if (r_estado == LIVRE) begin
            if ((r_pend_sobe != '0) && (r_pend_desce != '0)) begin
                w_emite_sobe  = ~r_ultimo_sobe;
                w_emite_desce = r_ultimo_sobe;
            end else begin
                w_emite_sobe  = (r_pend_sobe != '0);
                w_emite_desce = (r_pend_desce != '0);
            end
        end
    end

    // Credits and debits are accumulated separately: the counter saturates,
    // so they must never cancel each other here.
    assign w_soma_sobe  = SW'(r_pend_sobe) - SW'(w_emite_sobe) + SW'(bus.acerto)
                        + (bus.bonus ? SW'(bus.bonus_valor) : '0);
    assign w_soma_desce = SW'(r_pend_desce) - SW'(w_emite_desce) + SW'(bus.erro);
    assign w_sat_sobe   = satura(w_soma_sobe);
    assign w_sat_desce  = satura(w_soma_desce);

    // Next state, gap count and registered outputs; iniciar overrides everything.
    always_comb begin
        w_estado_prox     = r_estado;
        w_gap_prox        = r_gap;
        w_ultimo_prox     = r_ultimo_sobe;
        w_pend_sobe_prox  = w_sat_sobe[PW-1:0];
        w_pend_desce_prox = w_sat_desce[PW-1:0];
        w_perda_prox      = r_perda | w_sat_sobe[PW] | w_sat_desce[PW];
        w_inc_prox        = w_emite_sobe;
        w_dec_prox        = w_emite_desce;
        w_zera_prox       = 1'b0;

        if (bus.iniciar) begin
            w_estado_prox     = ZERA;
            w_gap_prox        = '0;
            w_ultimo_prox     = 1'b0;
            w_pend_sobe_prox  = '0;
            w_pend_desce_prox = '0;
            w_perda_prox      = 1'b0;
            w_inc_prox        = 1'b0;
            w_dec_prox        = 1'b0;
            w_zera_prox       = 1'b1;
        end else begin
            case (r_estado)
                LIVRE: begin
                    if (w_emite_sobe | w_emite_desce) begin
                        w_ultimo_prox = w_emite_sobe;
                        if (INTERVALO > 0) begin
                            w_estado_prox = ESPERA;
                            w_gap_prox    = GAP_INI;
                        end
                    end
                end
                ESPERA: begin
                    if (r_gap == '0) begin
                        w_estado_prox = LIVRE;
                    end else begin
                        w_gap_prox = r_gap - GW'(1);
                    end
                end
                ZERA:    w_estado_prox = LIVRE;
                default: w_estado_prox = LIVRE;
            endcase
        end

        w_ocupado_prox = (w_pend_sobe_prox != '0) | (w_pend_desce_prox != '0)
                       | (w_estado_prox != LIVRE) | w_inc_prox | w_dec_prox;
    end

    // FSM state, gap counter and direction memory.
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            r_estado      <= LIVRE;
            r_gap         <= '0;
            r_ultimo_sobe <= 1'b0;
        end else begin
            r_estado      <= w_estado_prox;
            r_gap         <= w_gap_prox;
            r_ultimo_sobe <= w_ultimo_prox;
        end
    end

    // Pending queues and output registers; reset drops all pending work at once.
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            r_pend_sobe  <= '0;
            r_pend_desce <= '0;
            r_inc        <= 1'b0;
            r_dec        <= 1'b0;
            r_zera_s     <= 1'b0;
            r_ocupado    <= 1'b0;
            r_perda      <= 1'b0;
        end else begin
            r_pend_sobe  <= w_pend_sobe_prox;
            r_pend_desce <= w_pend_desce_prox;
            r_inc        <= w_inc_prox;
            r_dec        <= w_dec_prox;
            r_zera_s     <= w_zera_prox;
            r_ocupado    <= w_ocupado_prox;
            r_perda      <= w_perda_prox;
        end
    end

    assign bus.inc        = r_inc;
    assign bus.dec        = r_dec;
    assign bus.zera_s     = r_zera_s;
    assign bus.pend_sobe  = r_pend_sobe;
    assign bus.pend_desce = r_pend_desce;
    assign bus.ocupado    = r_ocupado;
    assign bus.perda      = r_perda;

endmodule

// File: tb/tb_controle_pontuacao.sv
// Bench for controle_pontuacao: two instances (INTERVALO=0 and INTERVALO=2)
// share one stimulus stream and are compared against a queue-level model.
module tb_controle_pontuacao;
    localparam int PW   = 4;
    localparam int BW   = 4;
    localparam int PMAX = 15;

    logic          clock = 1'b0;
    logic          zera_as_n = 1'b0;
    logic          iniciar = 1'b0;
    logic          acerto = 1'b0;
    logic          erro = 1'b0;
    logic          bonus = 1'b0;
    logic [BW-1:0] bonus_valor = '0;

    int n_vet  = 0;
    int n_erro = 0;

    always #5 clock = ~clock;

    controle_pontuacao_if #(.PW(PW), .BW(BW)) bus0 ();
    controle_pontuacao_if #(.PW(PW), .BW(BW)) bus2 ();

    assign bus0.iniciar = iniciar;  assign bus2.iniciar = iniciar;
    assign bus0.acerto  = acerto;   assign bus2.acerto  = acerto;
    assign bus0.erro    = erro;     assign bus2.erro    = erro;
    assign bus0.bonus   = bonus;    assign bus2.bonus   = bonus;
    assign bus0.bonus_valor = bonus_valor;
    assign bus2.bonus_valor = bonus_valor;

    controle_pontuacao #(.PMAX(PMAX), .PW(PW), .BW(BW), .INTERVALO(0)) dut0 (
        .clock(clock), .zera_as_n(zera_as_n), .bus(bus0.slave));
    controle_pontuacao #(.PMAX(PMAX), .PW(PW), .BW(BW), .INTERVALO(2)) dut2 (
        .clock(clock), .zera_as_n(zera_as_n), .bus(bus2.slave));

    // {inc, dec, zera_s, pend_sobe, pend_desce, ocupado, perda}
    logic [12:0] obs0, obs2;
    assign obs0 = {bus0.inc, bus0.dec, bus0.zera_s, bus0.pend_sobe, bus0.pend_desce, bus0.ocupado, bus0.perda};
    assign obs2 = {bus2.inc, bus2.dec, bus2.zera_s, bus2.pend_sobe, bus2.pend_desce, bus2.ocupado, bus2.perda};

    function automatic logic [12:0] observa(int k);
        return (k == 0) ? obs0 : obs2;
    endfunction

    // Reference model: two pending queues, a "cycles until next pulse" budget,
    // the direction of the last pulse and a flag for the clear cycle.
    int m_ps[2], m_pd[2], m_bloq[2];
    bit m_ult_sobe[2], m_inc[2], m_dec[2], m_zera[2], m_perda[2];

    function automatic int intv(int k);
        return (k == 0) ? 0 : 2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ps[k] = 0; m_pd[k] = 0; m_bloq[k] = 0;
            m_ult_sobe[k] = 1'b0; m_inc[k] = 1'b0; m_dec[k] = 1'b0;
            m_zera[k] = 1'b0; m_perda[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        int is, id, a, d;
        for (int k = 0; k < 2; k++) begin
            if (iniciar) begin
                m_ps[k] = 0; m_pd[k] = 0; m_bloq[k] = 0; m_perda[k] = 1'b0;
                m_ult_sobe[k] = 1'b0; m_inc[k] = 1'b0; m_dec[k] = 1'b0;
                m_zera[k] = 1'b1;
            end else begin
                is = 0; id = 0;
                if (!m_zera[k] && m_bloq[k] == 0) begin
                    if (m_ps[k] > 0 && m_pd[k] > 0) begin
                        if (m_ult_sobe[k]) id = 1; else is = 1;
                    end else if (m_ps[k] > 0) begin
                        is = 1;
                    end else if (m_pd[k] > 0) begin
                        id = 1;
                    end
                end else if (m_bloq[k] > 0) begin
                    m_bloq[k] = m_bloq[k] - 1;
                end
                if (is + id > 0) begin
                    m_ult_sobe[k] = (is == 1);
                    m_bloq[k] = intv(k);
                end
                a = m_ps[k] - is + int'(acerto) + (bonus ? int'(bonus_valor) : 0);
                d = m_pd[k] - id + int'(erro);
                if (a > PMAX) begin a = PMAX; m_perda[k] = 1'b1; end
                if (d > PMAX) begin d = PMAX; m_perda[k] = 1'b1; end
                m_ps[k] = a; m_pd[k] = d;
                m_inc[k] = (is == 1); m_dec[k] = (id == 1);
                m_zera[k] = 1'b0;
            end
        end
    endtask

    function automatic logic [12:0] esperado(int k);
        logic oc;
        oc = (m_ps[k] != 0) || (m_pd[k] != 0) || (m_bloq[k] > 0) || m_zera[k] || m_inc[k] || m_dec[k];
        return {m_inc[k], m_dec[k], m_zera[k], 4'(m_ps[k]), 4'(m_pd[k]), oc, m_perda[k]};
    endfunction

    // Advance one clock edge (DUT and model together); returns #1 after the edge.
    task automatic passo();
        @(posedge clock);
        if (!zera_as_n) model_reset(); else model_step();
        #1;
    endtask

    task automatic test_reset();
        acerto = 1'b1; bonus = 1'b1; bonus_valor = 4'd9; erro = 1'b1;
        for (int c = 0; c < 4; c++) begin
            passo();
            for (int k = 0; k < 2; k++) begin
                n_vet++;
                if (observa(k) !== 13'd0) begin
                    n_erro++;
                    $display("FAIL reset_saidas dut%0d ciclo %0d: obtido=%h esperado=0", k * 2, c, observa(k));
                end
            end
        end
        acerto = 1'b0; bonus = 1'b0; bonus_valor = '0; erro = 1'b0;
        zera_as_n = 1'b1;
        passo();
        for (int k = 0; k < 2; k++) begin
            n_vet++;
            if (observa(k) !== esperado(k)) begin
                n_erro++;
                $display("FAIL reset_liberado dut%0d: obtido=%h esperado=%h", k * 2, observa(k), esperado(k));
            end
        end
    endtask

    task automatic test_acerto();
        acerto = 1'b1;
        passo();
        acerto = 1'b0;
        n_vet++;
        if (bus0.pend_sobe !== 4'd1 || bus0.inc !== 1'b0 || bus0.ocupado !== 1'b1) begin
            n_erro++;
            $display("FAIL acerto_pend: pend=%0d inc=%b ocup=%b esperado pend=1 inc=0 ocup=1",
                     bus0.pend_sobe, bus0.inc, bus0.ocupado);
        end
        passo();
        n_vet++;
        if (bus0.inc !== 1'b1 || bus0.pend_sobe !== 4'd0 || bus0.dec !== 1'b0) begin
            n_erro++;
            $display("FAIL acerto_pulso: inc=%b dec=%b pend=%0d esperado inc=1 dec=0 pend=0",
                     bus0.inc, bus0.dec, bus0.pend_sobe);
        end
        passo();
        n_vet++;
        if (bus0.inc !== 1'b0 || bus0.ocupado !== 1'b0) begin
            n_erro++;
            $display("FAIL acerto_fim: inc=%b ocup=%b esperado 0 0", bus0.inc, bus0.ocupado);
        end
        for (int k = 0; k < 2; k++) begin
            n_vet++;
            if (observa(k) !== esperado(k)) begin
                n_erro++;
                $display("FAIL acerto_modelo dut%0d: obtido=%h esperado=%h", k * 2, observa(k), esperado(k));
            end
        end
        repeat (6) passo();
    endtask

    task automatic test_bonus();
        int pulsos, ultimo_ciclo;
        pulsos = 0; ultimo_ciclo = -1;
        bonus = 1'b1; bonus_valor = 4'd5;
        passo();
        bonus = 1'b0; bonus_valor = '0;
        n_vet++;
        if (bus2.pend_sobe !== 4'd5) begin
            n_erro++;
            $display("FAIL bonus_pend: obtido=%0d esperado=5", bus2.pend_sobe);
        end
        for (int c = 0; c < 20; c++) begin
            passo();
            n_vet++;
            if (observa(1) !== esperado(1)) begin
                n_erro++;
                $display("FAIL bonus_modelo ciclo %0d: obtido=%h esperado=%h", c, observa(1), esperado(1));
            end
            if (bus2.dec !== 1'b0) begin
                n_vet++; n_erro++;
                $display("FAIL bonus_dec ciclo %0d: dec=%b esperado 0", c, bus2.dec);
            end
            if (bus2.inc === 1'b1) begin
                pulsos++;
                n_vet++;
                if (bus2.pend_sobe !== 4'(5 - pulsos)) begin
                    n_erro++;
                    $display("FAIL bonus_contagem pulso %0d: pend=%0d esperado=%0d", pulsos, bus2.pend_sobe, 5 - pulsos);
                end
                if (ultimo_ciclo >= 0) begin
                    n_vet++;
                    if (c - ultimo_ciclo != 3) begin
                        n_erro++;
                        $display("FAIL bonus_espaco pulso %0d: obtido=%0d esperado=3", pulsos, c - ultimo_ciclo);
                    end
                end
                ultimo_ciclo = c;
            end
        end
        n_vet++;
        if (pulsos != 5) begin
            n_erro++;
            $display("FAIL bonus_total: obtido=%0d esperado=5", pulsos);
        end
    endtask

    task automatic test_contencao();
        int seq[$];
        iniciar = 1'b1;
        passo();
        iniciar = 1'b0;
        for (int c = 0; c < 15; c++) begin
            acerto = (c < 3); erro = (c < 3);
            passo();
            n_vet++;
            if (bus0.inc === 1'b1 && bus0.dec === 1'b1) begin
                n_erro++;
                $display("FAIL contencao_ambos ciclo %0d: inc=1 dec=1 esperado exclusivos", c);
            end
            n_vet++;
            if (observa(0) !== esperado(0)) begin
                n_erro++;
                $display("FAIL contencao_modelo ciclo %0d: obtido=%h esperado=%h", c, observa(0), esperado(0));
            end
            if (bus0.inc === 1'b1) seq.push_back(1);
            if (bus0.dec === 1'b1) seq.push_back(2);
        end
        acerto = 1'b0; erro = 1'b0;
        n_vet++;
        if (seq.size() != 6) begin
            n_erro++;
            $display("FAIL contencao_total: obtido=%0d pulsos esperado=6", seq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vet++;
                if (seq[i] != ((i % 2 == 0) ? 1 : 2)) begin
                    n_erro++;
                    $display("FAIL contencao_ordem pulso %0d: obtido=%0d esperado=%0d (1=inc 2=dec)",
                             i, seq[i], (i % 2 == 0) ? 1 : 2);
                end
            end
        end
        repeat (10) passo();
    endtask

    task automatic test_saturacao();
        iniciar = 1'b1;
        passo();
        iniciar = 1'b0;
        bonus = 1'b1; bonus_valor = 4'd10;
        passo();
        passo();
        bonus = 1'b0; bonus_valor = '0;
        for (int k = 0; k < 2; k++) begin
            n_vet++;
            if (observa(k) !== esperado(k) || observa(k)[9:6] !== 4'd15 || observa(k)[0] !== 1'b1) begin
                n_erro++;
                $display("FAIL saturacao_pico dut%0d: obtido=%h esperado=%h (pend=15 perda=1)",
                         k * 2, observa(k), esperado(k));
            end
        end
        for (int c = 0; c < 20; c++) begin
            passo();
            n_vet++;
            if (bus0.perda !== 1'b1 || bus2.perda !== 1'b1) begin
                n_erro++;
                $display("FAIL saturacao_perda_fixa ciclo %0d: perda0=%b perda2=%b esperado 1", c, bus0.perda, bus2.perda);
            end
        end
        iniciar = 1'b1;
        passo();
        iniciar = 1'b0;
        n_vet++;
        if (bus0.perda !== 1'b0 || bus2.perda !== 1'b0) begin
            n_erro++;
            $display("FAIL saturacao_perda_limpa: perda0=%b perda2=%b esperado 0", bus0.perda, bus2.perda);
        end
        repeat (60) passo();
    endtask

    task automatic test_iniciar();
        bonus = 1'b1; bonus_valor = 4'd7;
        passo();
        bonus = 1'b0; bonus_valor = '0;
        n_vet++;
        if (bus0.pend_sobe !== 4'd7 || bus2.pend_sobe !== 4'd7) begin
            n_erro++;
            $display("FAIL iniciar_pend7: obtido=%0d/%0d esperado=7", bus0.pend_sobe, bus2.pend_sobe);
        end
        iniciar = 1'b1; acerto = 1'b1;
        passo();
        iniciar = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_vet++;
            if (observa(k)[12:10] !== 3'b001 || observa(k)[9:6] !== 4'd0 || observa(k)[0] !== 1'b0) begin
                n_erro++;
                $display("FAIL iniciar_zera dut%0d: obtido=%h esperado inc=0 dec=0 zera_s=1 pend=0 perda=0",
                         k * 2, observa(k));
            end
        end
        passo();
        acerto = 1'b0;
        n_vet++;
        if (bus0.pend_sobe !== 4'd1 || bus0.zera_s !== 1'b0 || bus0.inc !== 1'b0) begin
            n_erro++;
            $display("FAIL iniciar_acerto_zera: pend=%0d zera_s=%b inc=%b esperado 1 0 0",
                     bus0.pend_sobe, bus0.zera_s, bus0.inc);
        end
        passo();
        for (int k = 0; k < 2; k++) begin
            n_vet++;
            if (observa(k)[12] !== 1'b1 || observa(k) !== esperado(k)) begin
                n_erro++;
                $display("FAIL iniciar_inc_apos dut%0d: obtido=%h esperado=%h (inc=1)", k * 2, observa(k), esperado(k));
            end
        end
        repeat (6) passo();
    endtask

    task automatic test_reset_assincrono();
        bonus = 1'b1; bonus_valor = 4'd15;
        passo();
        bonus = 1'b0; bonus_valor = '0;
        passo();
        passo();
        n_vet++;
        if (bus0.inc !== 1'b1) begin
            n_erro++;
            $display("FAIL rst_async_drenando: inc=%b esperado 1", bus0.inc);
        end
        #2;
        zera_as_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vet++;
            if (observa(k) !== 13'd0) begin
                n_erro++;
                $display("FAIL rst_async_imediato dut%0d: obtido=%h esperado=0", k * 2, observa(k));
            end
        end
        model_reset();
        passo();
        zera_as_n = 1'b1;
        passo();
        for (int k = 0; k < 2; k++) begin
            n_vet++;
            if (observa(k) !== esperado(k)) begin
                n_erro++;
                $display("FAIL rst_async_retorno dut%0d: obtido=%h esperado=%h", k * 2, observa(k), esperado(k));
            end
        end
    endtask

    task automatic test_aleatorio();
        bit intenso;
        for (int c = 0; c < 3000; c++) begin
            intenso     = ((c / 500) % 2) == 1;
            iniciar     = ($urandom_range(63) == 0);
            acerto      = intenso ? ($urandom_range(1) == 0) : ($urandom_range(7) == 0);
            erro        = intenso ? ($urandom_range(2) == 0) : ($urandom_range(5) == 0);
            bonus       = intenso ? ($urandom_range(4) == 0) : ($urandom_range(15) == 0);
            bonus_valor = BW'($urandom_range(15));
            passo();
            for (int k = 0; k < 2; k++) begin
                n_vet++;
                if (observa(k) !== esperado(k)) begin
                    n_erro++;
                    $display("FAIL aleatorio dut%0d ciclo %0d: obtido=%h esperado=%h", k * 2, c, observa(k), esperado(k));
                end
            end
            n_vet++;
            if ((bus0.inc & bus0.dec) === 1'b1 || (bus2.inc & bus2.dec) === 1'b1) begin
                n_erro++;
                $display("FAIL aleatorio_exclusao ciclo %0d: inc0=%b dec0=%b inc2=%b dec2=%b esperado nao simultaneos",
                         c, bus0.inc, bus0.dec, bus2.inc, bus2.dec);
            end
        end
        iniciar = 1'b0; acerto = 1'b0; erro = 1'b0; bonus = 1'b0; bonus_valor = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_acerto();
        test_bonus();
        test_contencao();
        test_saturacao();
        test_iniciar();
        test_reset_assincrono();
        test_aleatorio();
        $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_erro);
        $finish;
    end

endmodule
